// File: rtl/bus_slave_resp_mux.sv
// Registered slave response mux: tracks one outstanding access, selects the responder by chip-select.
// Optional WAIT timeout with error response is enabled by defining SLAVE_MUX_TIMEOUT_EN.
module bus_slave_resp_mux #(
    parameter int                N_SLAVES = 8,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_SLAVES-1:0]          s_cs,
    input  logic [N_SLAVES-1:0]          s_ready,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rd_data,
    output logic [DATA_W-1:0]            m_rd_data,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [$clog2(N_SLAVES)-1:0]  m_sel_idx,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_SLAVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;

    logic [DATA_W-1:0] slave_data [N_SLAVES];
    logic [IDX_W-1:0]  low_idx;
    logic              multi_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_slice
            assign slave_data[gi] = s_rd_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from the top so the lowest asserted chip-select wins.
    always_comb begin
        low_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (s_cs[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        multi_sel = (s_cs & (s_cs - N_SLAVES'(1))) != '0;
    end

`ifdef SLAVE_MUX_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    logic [TIMER_W-1:0] timer_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            m_rd_data <= '0;
            m_ready   <= 1'b0;
            m_err     <= 1'b0;
            m_sel_idx <= '0;
            busy      <= 1'b0;
`ifdef SLAVE_MUX_TIMEOUT_EN
            timer_reg <= '0;
`endif
        end else begin
            // Response strobe and data are one-cycle pulses; data is zero otherwise.
            m_ready   <= 1'b0;
            m_err     <= 1'b0;
            m_rd_data <= '0;
            case (state_reg)
                IDLE: begin
                    if (|s_cs) begin
                        m_sel_idx <= low_idx;
                        busy      <= 1'b1;
                        if (multi_sel) begin
                            state_reg <= DONE;
                            m_ready   <= 1'b1;
                            m_err     <= 1'b1;
                            m_rd_data <= ERR_DATA;
                        end else if (s_ready[low_idx]) begin
                            state_reg <= DONE;
                            m_ready   <= 1'b1;
                            m_rd_data <= slave_data[low_idx];
                        end else begin
                            state_reg <= WAIT;
`ifdef SLAVE_MUX_TIMEOUT_EN
                            timer_reg <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (!s_cs[m_sel_idx]) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (s_ready[m_sel_idx]) begin
                        state_reg <= DONE;
                        m_ready   <= 1'b1;
                        m_rd_data <= slave_data[m_sel_idx];
`ifdef SLAVE_MUX_TIMEOUT_EN
                    end else if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
                        state_reg <= DONE;
                        m_ready   <= 1'b1;
                        m_err     <= 1'b1;
                        m_rd_data <= ERR_DATA;
                    end else if (timer_reg < TIMER_W'(TIMEOUT)) begin
                        timer_reg <= timer_reg + TIMER_W'(1);
`endif
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_resp_mux.sv
// Directed bench for bus_slave_resp_mux: vector table of single accesses plus multi-cycle sequences.
module tb_bus_slave_resp_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_cs;
    logic [7:0]  s_ready;
    logic [255:0] s_rd_data;
    logic [31:0] m_rd_data;
    logic        m_ready;
    logic        m_err;
    logic [2:0]  m_sel_idx;
    logic        busy;

    int tests = 0;
    int fails = 0;

    bus_slave_resp_mux #(
        .N_SLAVES(8),
        .DATA_W  (32),
        .TIMEOUT (4),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_cs     (s_cs),
        .s_ready  (s_ready),
        .s_rd_data(s_rd_data),
        .m_rd_data(m_rd_data),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .m_sel_idx(m_sel_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cs;
        logic [7:0]  rdy;
        logic [31:0] base;
        logic        e_ready;
        logic        e_err;
        logic [31:0] e_data;
        logic [2:0]  e_idx;
        logic        e_busy;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave k returns base + k.
    task automatic set_data(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            s_rd_data[k*32 +: 32] = base + 32'(k);
        end
    endtask

    task automatic clear_inputs();
        s_cs    = '0;
        s_ready = '0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ready0"}, 64'(m_ready), 64'd0);
        chk({name, "_data0"}, 64'(m_rd_data), 64'd0);
        chk({name, "_busy0"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        int hits;

        vecs[0] = '{8'h04, 8'h04, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 3'd2, 1'b1};
        vecs[1] = '{8'h22, 8'h00, 32'h0000_0001, 1'b1, 1'b1, 32'hDEAD_BEEF, 3'd1, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 32'h1000_0000, 1'b1, 1'b0, 32'h1000_0007, 3'd7, 1'b1};
        vecs[3] = '{8'h01, 8'hFE, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0000, 3'd0, 1'b1};
        vecs[4] = '{8'h03, 8'h03, 32'h0000_0009, 1'b1, 1'b1, 32'hDEAD_BEEF, 3'd0, 1'b1};
        vecs[5] = '{8'h40, 8'h40, 32'hFFFF_FFF0, 1'b1, 1'b0, 32'hFFFF_FFF6, 3'd6, 1'b1};
        vecs[6] = '{8'h00, 8'hFF, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 3'd6, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 3'd7, 1'b1};

        reset = 1'b0;
        clear_inputs();
        set_data(32'h0);
        step();
        step();
        chk("rst_ready", 64'(m_ready), 64'd0);
        chk("rst_err", 64'(m_err), 64'd0);
        chk("rst_data", 64'(m_rd_data), 64'd0);
        chk("rst_idx", 64'(m_sel_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        step();
        chk_idle("post_rst");

        // Table: one access from IDLE, then inputs cleared (DONE->IDLE or WAIT abort).
        for (int v = 0; v < 8; v++) begin
            s_cs    = vecs[v].cs;
            s_ready = vecs[v].rdy;
            set_data(vecs[v].base);
            step();
            $display("[TB] vec %0d cs=%02h rdy=%02h -> ready=%0b err=%0b data=%08h idx=%0d busy=%0b",
                     v, vecs[v].cs, vecs[v].rdy, m_ready, m_err, m_rd_data, m_sel_idx, busy);
            chk($sformatf("vec%0d_ready", v), 64'(m_ready), 64'(vecs[v].e_ready));
            chk($sformatf("vec%0d_err", v), 64'(m_err), 64'(vecs[v].e_err));
            chk($sformatf("vec%0d_data", v), 64'(m_rd_data), 64'(vecs[v].e_data));
            chk($sformatf("vec%0d_idx", v), 64'(m_sel_idx), 64'(vecs[v].e_idx));
            chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(vecs[v].e_busy));
            clear_inputs();
            step();
            chk_idle($sformatf("vec%0d_after", v));
        end

        // Slave 0 waits three cycles, then responds.
        s_cs = 8'h01;
        s_ready = 8'h00;
        set_data(32'h1234_5678);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("wait%0d_busy", c), 64'(busy), 64'd1);
            chk($sformatf("wait%0d_ready", c), 64'(m_ready), 64'd0);
        end
        s_ready = 8'h01;
        step();
        $display("[TB] wait access -> ready=%0b err=%0b data=%08h", m_ready, m_err, m_rd_data);
        chk("wait_resp_ready", 64'(m_ready), 64'd1);
        chk("wait_resp_data", 64'(m_rd_data), 64'h1234_5678);
        chk("wait_resp_err", 64'(m_err), 64'd0);
        clear_inputs();
        step();
        chk_idle("wait_after");

        // cs held high through DONE starts a second access in the following IDLE cycle.
        s_cs = 8'h10;
        s_ready = 8'h10;
        set_data(32'h0);
        step();
        chk("b2b_first", 64'(m_ready), 64'd1);
        chk("b2b_data", 64'(m_rd_data), 64'h4);
        step();
        chk("b2b_gap", 64'(m_ready), 64'd0);
        step();
        $display("[TB] back-to-back second -> ready=%0b idx=%0d", m_ready, m_sel_idx);
        chk("b2b_second", 64'(m_ready), 64'd1);
        chk("b2b_idx", 64'(m_sel_idx), 64'd4);
        clear_inputs();
        step();
        chk_idle("b2b_after");

        // Slave 7 never ready: timeout error, or indefinite wait without the timer.
        s_cs = 8'h80;
        s_ready = 8'h00;
`ifdef SLAVE_MUX_TIMEOUT_EN
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (m_ready && n == 0) begin
                n = c;
                chk("to_err", 64'(m_err), 64'd1);
                chk("to_data", 64'(m_rd_data), 64'hDEAD_BEEF);
            end
        end
        $display("[TB] timeout -> response after %0d cycles", n);
        chk("to_latency", 64'(n), 64'd5);
`else
        hits = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (m_ready) hits++;
        end
        $display("[TB] no-timeout hold -> %0d responses in 100 cycles, busy=%0b", hits, busy);
        chk("hold_no_resp", 64'(hits), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
`endif
        clear_inputs();
        step();
        step();
        chk_idle("to_after");

        // Abort: slave 3 in WAIT; other slaves' cs/ready are ignored until cs[3] drops.
        s_cs = 8'h08;
        s_ready = 8'h00;
        step();
        s_cs = 8'h48;
        s_ready = 8'h40;
        step();
        chk("abort_ignore_ready", 64'(m_ready), 64'd0);
        chk("abort_ignore_busy", 64'(busy), 64'd1);
        chk("abort_ignore_idx", 64'(m_sel_idx), 64'd3);
        s_cs = 8'h00;
        s_ready = 8'h40;
        step();
        $display("[TB] abort -> ready=%0b busy=%0b", m_ready, busy);
        chk_idle("abort");
        clear_inputs();
        step();
        chk_idle("abort_after");

        // Reset in WAIT clears outputs asynchronously; a fresh access then completes.
        s_cs = 8'h04;
        s_ready = 8'h00;
        step();
        chk("rstw_busy_pre", 64'(busy), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_idx", 64'(m_sel_idx), 64'd0);
        chk("rstw_ready", 64'(m_ready), 64'd0);
        clear_inputs();
        #1;
        reset = 1'b1;
        step();
        chk_idle("rstw_idle");
        s_cs = 8'h02;
        s_ready = 8'h02;
        set_data(32'h50);
        step();
        $display("[TB] post-reset access -> ready=%0b data=%08h idx=%0d", m_ready, m_rd_data, m_sel_idx);
        chk("rstw_new_ready", 64'(m_ready), 64'd1);
        chk("rstw_new_data", 64'(m_rd_data), 64'h51);
        chk("rstw_new_idx", 64'(m_sel_idx), 64'd1);
        chk("rstw_new_err", 64'(m_err), 64'd0);
        clear_inputs();
        step();
        chk_idle("rstw_new_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
